// File: rtl/frame1101_tx.sv
// Serial frame transmitter: preamble 1101, MSB-first payload with zero-bit stuffing, idle gap.
// Define FRAME_PARITY_EN to append an even-parity bit after the payload LSB.
module frame1101_tx #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              frame_active,
    output logic              done
);

`ifdef FRAME_PARITY_EN
    localparam int unsigned FRAME_W = DATA_W + 1;
`else
    localparam int unsigned FRAME_W = DATA_W;
`endif
    localparam int unsigned RW = $clog2(FRAME_W + 1);
    localparam int unsigned GW = $clog2(GAP_LEN + 1);
    localparam logic [3:0] PREAMBLE = 4'b1101;

    typedef enum logic [2:0] {IDLE, PRE, DATA, STUFF, GAP} state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [1:0]         pre_idx_q, pre_idx_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [2:0]         hist_q, hist_d;
    logic               out_q, out_d;
    logic               frame_active_q, frame_active_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic [FRAME_W-1:0] load_word;
    logic [1:0]         pre_sel;
    logic               emit;

`ifdef FRAME_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    assign pre_sel = ~pre_idx_q;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        rem_d          = rem_q;
        pre_idx_d      = pre_idx_q;
        gap_cnt_d      = gap_cnt_q;
        hist_d         = hist_q;
        out_d          = out_q;
        frame_active_d = frame_active_q;
        done_d         = 1'b0;
        emit           = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    state_d        = PRE;
                    pre_idx_d      = 2'd1;
                    out_d          = PREAMBLE[3];
                    frame_active_d = 1'b1;
                    // history cleared, then the first preamble bit shifted in
                    hist_d         = {2'b00, PREAMBLE[3]};
                    shreg_d        = load_word;
                    rem_d          = RW'(FRAME_W);
                end
            end
            PRE: begin
                if (pre_idx_q != 2'd0) begin
                    out_d     = PREAMBLE[pre_sel];
                    pre_idx_d = pre_idx_q + 2'd1;
                end else begin
                    emit = 1'b1;
                end
            end
            DATA, STUFF: emit = 1'b1;
            GAP: begin
                out_d = 1'b0;
                if (gap_cnt_q == GW'(GAP_LEN)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d        = IDLE;
                out_d          = 1'b0;
                frame_active_d = 1'b0;
            end
        endcase

        // Next line bit once the preamble is out: end of frame, stuffed zero, or payload bit.
        if (emit) begin
            if (rem_q == '0) begin
                state_d        = GAP;
                out_d          = 1'b0;
                frame_active_d = 1'b0;
                done_d         = 1'b1;
                gap_cnt_d      = GW'(1);
            end else if (hist_q == 3'b110) begin
                state_d = STUFF;
                out_d   = 1'b0;
            end else begin
                state_d = DATA;
                out_d   = shreg_q[FRAME_W-1];
                shreg_d = shreg_q << 1;
                rem_d   = rem_q - RW'(1);
            end
        end

        if (state_q != IDLE && frame_active_d) begin
            hist_d = {hist_q[1:0], out_d};
        end

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            rem_q          <= '0;
            pre_idx_q      <= '0;
            gap_cnt_q      <= '0;
            hist_q         <= '0;
            out_q          <= 1'b0;
            frame_active_q <= 1'b0;
            done_q         <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            rem_q          <= rem_d;
            pre_idx_q      <= pre_idx_d;
            gap_cnt_q      <= gap_cnt_d;
            hist_q         <= hist_d;
            out_q          <= out_d;
            frame_active_q <= frame_active_d;
            done_q         <= done_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign out          = out_q;
    assign frame_active = frame_active_q;
    assign done         = done_q;
    assign in_ready     = in_ready_q;

endmodule

// File: tb/tb_frame1101_tx.sv
// Self-checking bench for frame1101_tx: directed and random frames against a queue-based frame model.
module tb_frame1101_tx;
    localparam int unsigned DW = 8;
    localparam int unsigned GL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out;
    logic          frame_active;
    logic          done;

    int          total = 0;
    int          bad   = 0;
    int          done_seen = 0;
    bit          exp_q[$];
    logic [31:0] obs_bits;
    int          obs_len;

    always #5 clk = ~clk;

    frame1101_tx #(.DATA_W(DW), .GAP_LEN(GL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out(out), .frame_active(frame_active), .done(done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected line bits: preamble, then each payload bit preceded by a 0 whenever the
    // last three emitted bits read 1,1,0.
    task automatic build_exp(input logic [DW-1:0] w);
        bit pay[$];
        int n;
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int i = DW - 1; i >= 0; i--) pay.push_back(w[i]);
`ifdef FRAME_PARITY_EN
        pay.push_back(($countones(w) % 2) == 1);
`endif
        foreach (pay[j]) begin
            n = exp_q.size();
            if (exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0)
                exp_q.push_back(1'b0);
            exp_q.push_back(pay[j]);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit hold);
        int t;
        int hits;
        logic [3:0] win;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(t < 50), 32'd1);
        build_exp(w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        obs_bits = '0; obs_len = 0; win = '0; hits = 0;
        foreach (exp_q[i]) begin
            @(negedge clk);
            in_valid = hold;
            in_data  = DW'($urandom);
            check("out", 32'(out), 32'(exp_q[i]));
            check("frame_active", 32'(frame_active), 32'd1);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("done_early", 32'(done), 32'd0);
            obs_bits = {obs_bits[30:0], out};
            obs_len++;
            win = {win[2:0], out};
            if (win == 4'b1101) hits++;
        end
        @(negedge clk);
        in_data = DW'($urandom);
        if (done === 1'b1) done_seen++;
        check("done_pulse", 32'(done), 32'd1);
        check("gap_out", 32'(out), 32'd0);
        check("gap_fa", 32'(frame_active), 32'd0);
        check("gap_ready", 32'(in_ready), 32'd0);
        win = {win[2:0], out};
        if (win == 4'b1101) hits++;
        for (int g = 1; g < int'(GL); g++) begin
            @(negedge clk);
            in_data = DW'($urandom);
            if (done === 1'b1) done_seen++;
            check("gap_done_low", 32'(done), 32'd0);
            check("gap_out", 32'(out), 32'd0);
            check("gap_ready", 32'(in_ready), 32'd0);
            win = {win[2:0], out};
            if (win == 4'b1101) hits++;
        end
        @(negedge clk);
        check("ready_after_gap", 32'(in_ready), 32'd1);
        check("idle_out", 32'(out), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("detector_hits", 32'(hits), 32'd1);
    endtask

    initial begin
        int d0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_fa", 32'(frame_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        send_frame(8'h00, 1'b0);
`ifdef FRAME_PARITY_EN
        check("len_00", 32'(obs_len), 32'd13);
        check("bits_00", obs_bits, 32'b1101000000000);
`else
        check("len_00", 32'(obs_len), 32'd12);
        check("bits_00", obs_bits, 32'b110100000000);
`endif
        in_valid = 1'b0;

        send_frame(8'hFF, 1'b0);
`ifdef FRAME_PARITY_EN
        check("bits_ff", obs_bits, 32'b1101111111110);
`else
        check("bits_ff", obs_bits, 32'b110111111111);
`endif
        send_frame(8'hDA, 1'b0);
`ifdef FRAME_PARITY_EN
        check("len_da", 32'(obs_len), 32'd15);
        check("bits_da", obs_bits, 32'b110111001100101);
`else
        check("len_da", 32'(obs_len), 32'd14);
        check("bits_da", obs_bits, 32'b11011100110010);
`endif
        repeat (3) @(negedge clk);
        send_frame(8'h6D, 1'b0);
`ifdef FRAME_PARITY_EN
        check("bits_6d", obs_bits, 32'b110101100110011);
`else
        check("bits_6d", obs_bits, 32'b11010110011001);
`endif

        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(DW'($urandom), 1'b0);
        end

        // back-to-back with in_valid held high
        d0 = done_seen;
        send_frame(DW'($urandom), 1'b1);
        send_frame(DW'($urandom), 1'b1);
        send_frame(DW'($urandom), 1'b1);
        in_valid = 1'b0;
        check("b2b_done_count", 32'(done_seen - d0), 32'd3);

        // reset while payload bits are on the line
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hDA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_fa_before", 32'(frame_active), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_fa", 32'(frame_active), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        send_frame(8'h00, 1'b0);
`ifdef FRAME_PARITY_EN
        check("post_rst_bits", obs_bits, 32'b1101000000000);
`else
        check("post_rst_bits", obs_bits, 32'b110100000000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
